// File: rtl/and_unit.sv
// 64-bit registered bitwise AND unit for the Y86-64 execute stage.
// Build macro AND_UNIT_FLAGS_EN enables the registered ZF/SF condition-code outputs.
module and_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [63:0] in1,
  input  logic [63:0] in2,
  output logic [63:0] out,
  output logic        out_valid,
  output logic        zf,
  output logic        sf,
  output logic        of
);

  logic [63:0] and_res;

  // One independent cell per bit; AND has no carry chain.
  for (genvar i = 0; i < 64; i++) begin : g_bit
    assign and_res[i] = in1[i] & in2[i];
  end

  // out holds its last value when idle; out_valid only marks a fresh result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= 64'h0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= and_res;
      end
    end
  end

`ifdef AND_UNIT_FLAGS_EN
  logic zf_q;
  logic sf_q;

  // Flags come from the same combinational result as out, so they never disagree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
    end else if (in_valid) begin
      zf_q <= (and_res == 64'h0);
      sf_q <= and_res[63];
    end
  end

  assign zf = zf_q;
  assign sf = sf_q;
`else
  assign zf = 1'b0;
  assign sf = 1'b0;
`endif

  // AND can never overflow.
  assign of = 1'b0;

endmodule

// File: tb/tb_and_unit.sv
// Directed self-checking bench for and_unit; flag expectations follow AND_UNIT_FLAGS_EN.
module tb_and_unit;

`ifdef AND_UNIT_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in1;
  logic [63:0] in2;
  logic [63:0] out;
  logic        out_valid;
  logic        zf;
  logic        sf;
  logic        of;

  int vectors;
  int miscompares;
  logic [63:0] exp_q[$];

  and_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in1      (in1),
    .in2      (in2),
    .out      (out),
    .out_valid(out_valid),
    .zf       (zf),
    .sf       (sf),
    .of       (of)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: change inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic v, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    in1      = a;
    in2      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks out plus flags derived from the expected result value.
  task automatic check_result(input string tag, input logic [63:0] exp_out, input logic exp_valid);
    check({tag, ".out"}, out, exp_out);
    check({tag, ".out_valid"}, {63'h0, out_valid}, {63'h0, exp_valid});
    check({tag, ".zf"}, {63'h0, zf}, {63'h0, FLAGS & (exp_out == 64'h0)});
    check({tag, ".sf"}, {63'h0, sf}, {63'h0, FLAGS & exp_out[63]});
    check({tag, ".of"}, {63'h0, of}, 64'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in1         = 64'h0;
    in2         = 64'h0;

    // Reset held two cycles with valid random operands.
    drive(1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
    drive(1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
    check_result("reset", 64'h0, 1'b0);
    check("reset.zf_value", {63'h0, zf}, {63'h0, FLAGS});

    // Zero and positive operands.
    drive(1'b1, 1'b1, 64'h0, 64'h0);
    check_result("zero_and_zero", 64'h0, 1'b1);
    drive(1'b1, 1'b1, 64'h26, 64'h31);
    check_result("pos_26_31", 64'h20, 1'b1);

    // Negative operands.
    drive(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFD3, 64'h15);
    check_result("neg45_and_15", 64'h11, 1'b1);
    drive(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFDF, 64'hFFFF_FFFF_FFFF_FFDE);
    check_result("neg33_and_neg34", 64'hFFFF_FFFF_FFFF_FFDE, 1'b1);

    // Back-to-back operations through the expected queue.
    exp_q.push_back(64'h08);
    exp_q.push_back(64'h29);
    drive(1'b1, 1'b1, 64'h0E, 64'h28);
    check_result("b2b_first", exp_q.pop_front(), 1'b1);
    drive(1'b1, 1'b1, 64'h2F, 64'h39);
    check_result("b2b_second", exp_q.pop_front(), 1'b1);

    // Hold: idle with changed operands keeps the last result.
    drive(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0);
    check_result("hold_1", 64'h29, 1'b0);
    drive(1'b1, 1'b0, 64'h0, 64'h0);
    check_result("hold_2", 64'h29, 1'b0);

    // Full-width pattern to exercise the upper bits.
    drive(1'b1, 1'b1, 64'hA5A5_0F0F_FFFF_0000, 64'hFF00_FF00_F0F0_FFFF);
    check_result("wide_mix", 64'hA500_0F00_F0F0_0000, 1'b1);

    // Reset on the same edge as a valid operation discards it.
    drive(1'b0, 1'b1, 64'hFF, 64'hFF);
    check_result("reset_mid", 64'h0, 1'b0);
    drive(1'b1, 1'b0, 64'hFF, 64'hFF);
    check_result("reset_mid_after", 64'h0, 1'b0);

    // First operation after reset release.
    drive(1'b1, 1'b1, 64'h8000_0000_0000_0001, 64'hC000_0000_0000_0003);
    check_result("post_reset", 64'h8000_0000_0000_0001, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
